// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Purpose  : Asserts reset asynchronously and releases it synchronously.
//            The reset is stretched to a minimum width, then released to
//            NUM_OUTPUTS domains one at a time at a fixed stagger.
//            Optional soft reset input: define RESET_SEQUENCER_SOFT_RESET_EN.
// Revision : 1.0  initial release
// ============================================================================
module reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int NUM_OUTPUTS    = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                   clock_in,
    input  logic                   n_reset_in,
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
    input  logic                   soft_reset_in,
`endif
    output logic [NUM_OUTPUTS-1:0] n_reset_out,
    output logic                   reset_done_out
);

    localparam int c_CNT_MAX = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_IDX_W   = $clog2(NUM_OUTPUTS + 1);

    localparam logic [c_CNT_W-1:0] c_STRETCH_LAST = c_CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_STAGGER_LAST = c_CNT_W'((STAGGER_CYCLES > 0) ? STAGGER_CYCLES - 1 : 0);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE      = c_CNT_W'(1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST     = c_IDX_W'(NUM_OUTPUTS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE      = c_IDX_W'(1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STRETCH = 2'd1,
        S_RELEASE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_ok;
    state_t                 state_q;
    logic [c_CNT_W-1:0]     cnt_q;
    logic [c_IDX_W-1:0]     idx_q;
    logic [NUM_OUTPUTS-1:0] n_reset_q;
    logic                   done_q;
    logic                   first_release;

    always_ff @(posedge clock_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_ok = sync_q[SYNC_STAGES-1];

    // The HOLD exit edge already counts as the first stretch cycle.
    assign first_release = ((state_q == S_HOLD) && sync_ok && (STRETCH_CYCLES == 1)) ||
                           ((state_q == S_STRETCH) && (cnt_q == c_STRETCH_LAST));

    always_ff @(posedge clock_in or negedge n_reset_in) begin
        if (!n_reset_in) begin
            state_q   <= S_HOLD;
            cnt_q     <= '0;
            idx_q     <= '0;
            n_reset_q <= '0;
            done_q    <= 1'b0;
        end
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
        else if (soft_reset_in) begin
            // Stay in HOLD until the synchroniser is ready, so a soft request
            // can never shorten the hard-reset timing.
            n_reset_q <= '0;
            done_q    <= 1'b0;
            cnt_q     <= '0;
            idx_q     <= '0;
            state_q   <= sync_ok ? S_STRETCH : S_HOLD;
        end
`endif
        else if (first_release) begin
            cnt_q <= '0;
            if ((NUM_OUTPUTS == 1) || (STAGGER_CYCLES == 0)) begin
                n_reset_q <= '1;
                state_q   <= S_DONE;
            end else begin
                n_reset_q[0] <= 1'b1;
                idx_q        <= c_IDX_ONE;
                state_q      <= S_RELEASE;
            end
        end else begin
            case (state_q)
                S_HOLD: begin
                    if (sync_ok) begin
                        state_q <= S_STRETCH;
                        cnt_q   <= c_CNT_ONE;
                    end
                end
                S_STRETCH: begin
                    cnt_q <= cnt_q + c_CNT_ONE;
                end
                S_RELEASE: begin
                    if (cnt_q == c_STAGGER_LAST) begin
                        cnt_q <= '0;
                        for (int i = 0; i < NUM_OUTPUTS; i++) begin
                            if (idx_q == c_IDX_W'(i)) begin
                                n_reset_q[i] <= 1'b1;
                            end
                        end
                        if (idx_q == c_IDX_LAST) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + c_IDX_ONE;
                        end
                    end else begin
                        cnt_q <= cnt_q + c_CNT_ONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state_q <= S_HOLD;
                end
            endcase
        end
    end

    assign n_reset_out    = n_reset_q;
    assign reset_done_out = done_q;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Purpose  : Randomised scoreboard bench for three reset_sequencer configs.
// Revision : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;

    logic       clk;
    logic       n_rst;
    wire  [3:0] a_out;
    wire        a_done;
    wire  [2:0] b_out;
    wire        b_done;
    wire  [0:0] c_out;
    wire        c_done;
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
    logic       soft;
`endif

    int          vectors    = 0;
    int          miscompares = 0;
    int          restarts   = 0;
    logic [10:0] exp_q[$];

    reset_sequencer #(.SYNC_STAGES(2), .NUM_OUTPUTS(4), .STRETCH_CYCLES(16), .STAGGER_CYCLES(8)) u_a (
        .clock_in(clk), .n_reset_in(n_rst),
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
        .soft_reset_in(soft),
`endif
        .n_reset_out(a_out), .reset_done_out(a_done));

    reset_sequencer #(.SYNC_STAGES(3), .NUM_OUTPUTS(3), .STRETCH_CYCLES(1), .STAGGER_CYCLES(0)) u_b (
        .clock_in(clk), .n_reset_in(n_rst),
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
        .soft_reset_in(soft),
`endif
        .n_reset_out(b_out), .reset_done_out(b_done));

    reset_sequencer #(.SYNC_STAGES(2), .NUM_OUTPUTS(1), .STRETCH_CYCLES(5), .STAGGER_CYCLES(8)) u_c (
        .clock_in(clk), .n_reset_in(n_rst),
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
        .soft_reset_in(soft),
`endif
        .n_reset_out(c_out), .reset_done_out(c_done));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: after edge k, output i is released once k reaches
    // base + STRETCH + i*STAGGER, where base is the synchroniser depth or the
    // last edge a soft request was sampled, whichever is later.
    function automatic logic [4:0] model(input int s, input int n, input int st,
                                         input int sg, input int kk, input int el);
        int         base;
        logic [4:0] r;
        base = (el > s) ? el : s;
        r    = '0;
        for (int i = 0; i < n; i++) begin
            if (kk >= base + st + i * sg) r[i] = 1'b1;
        end
        if (kk >= base + st + (n - 1) * sg + 1) r[4] = 1'b1;
        return r;
    endfunction

    // Model process: one expected word per rising edge.
    initial begin
        int         k;
        int         e_last;
        int         seen;
        logic [4:0] ea;
        logic [4:0] eb;
        logic [4:0] ec;
        k = 0; e_last = -1; seen = 0;
        forever begin
            @(posedge clk);
            if (restarts != seen) begin
                seen   = restarts;
                k      = 0;
                e_last = -1;
            end
            if (n_rst) begin
                k = k + 1;
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
                if (soft) e_last = k;
`endif
            end else begin
                k      = 0;
                e_last = -1;
            end
            ea = model(2, 4, 16, 8, k, e_last);
            eb = model(3, 3, 1, 0, k, e_last);
            ec = model(2, 1, 5, 8, k, e_last);
            exp_q.push_back({ea[4], ea[3:0], eb[4], eb[2:0], ec[4], ec[0]});
        end
    end

    // Monitor: pops and compares away from the clock edge.
    initial begin
        logic [10:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty at %0t: actual queue size 0, required >0", $time);
            end else begin
                e = exp_q.pop_front();
                vectors++;
                if ({a_done, a_out} !== e[10:6]) begin
                    miscompares++;
                    $display("FAIL cfg_a at %0t: actual done,out=%b required %b", $time, {a_done, a_out}, e[10:6]);
                end
                vectors++;
                if ({b_done, b_out} !== e[5:2]) begin
                    miscompares++;
                    $display("FAIL cfg_b at %0t: actual done,out=%b required %b", $time, {b_done, b_out}, e[5:2]);
                end
                vectors++;
                if ({c_done, c_out} !== e[1:0]) begin
                    miscompares++;
                    $display("FAIL cfg_c at %0t: actual done,out=%b required %b", $time, {c_done, c_out}, e[1:0]);
                end
            end
        end
    end

    task automatic check_async_clear(input string name);
        vectors++;
        if ({a_done, a_out, b_done, b_out, c_done, c_out} !== 11'b0) begin
            miscompares++;
            $display("FAIL %s at %0t: actual outputs=%b required all 0", name, $time,
                     {a_done, a_out, b_done, b_out, c_done, c_out});
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual time %0t, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int kind;
        int len;
        n_rst = 1'b0;
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
        soft = 1'b0;
`endif
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        for (int it = 0; it < 24; it++) begin
            len = (it % 2 == 0) ? int'($urandom_range(45, 60)) : int'($urandom_range(3, 44));
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
            if ($urandom_range(0, 2) == 0) begin
                repeat (len) @(negedge clk);
                soft = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                soft = 1'b0;
                len  = int'($urandom_range(20, 60));
            end
            kind = int'($urandom_range(0, 2));
`else
            kind = int'($urandom_range(0, 1));
`endif
            repeat (len) @(negedge clk);
            if (kind == 0) begin
                #2;
                n_rst    = 1'b0;
                restarts = restarts + 1;
                #1;
                check_async_clear("glitch_clear");
                n_rst = 1'b1;
            end else if (kind == 1) begin
                #2;
                n_rst = 1'b0;
                #1;
                check_async_clear("hard_clear");
                repeat ($urandom_range(1, 4)) @(negedge clk);
                n_rst = 1'b1;
            end else begin
`ifdef RESET_SEQUENCER_SOFT_RESET_EN
                soft = 1'b1;
                @(negedge clk);
                #2;
                n_rst = 1'b0;
                #1;
                check_async_clear("soft_and_hard_clear");
                repeat ($urandom_range(1, 3)) @(negedge clk);
                n_rst = 1'b1;
                repeat ($urandom_range(0, 5)) @(negedge clk);
                soft = 1'b0;
`endif
            end
        end
        repeat (60) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
